// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Pays out a change amount as a train of coin-eject pulses. Coins are chosen
// greedily, largest first, from 10/5/2/1. Each coin pulse is followed by
// COIN_GAP idle cycles so the hopper can settle. The per-denomination tallies
// and the remaining amount stay on the outputs after a transaction finishes,
// so the change display persists until the next accepted start.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      dispense request, only honoured while idle
//   amount     change to return, captured on the accepting edge
//   busy       high while a transaction is in progress (PICK/PULSE/GAP)
//   done       one-cycle completion pulse
//   coin_out   one-hot eject pulse {10, 5, 2, 1}, one cycle per coin
//   remaining  change still to be paid out
//   cnt10..cnt1  coins of each value ejected in the current transaction
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int AMT_W    = 5,
    parameter int COIN_GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [3:0]       coin_out,
    output logic [AMT_W-1:0] remaining,
    output logic [3:0]       cnt10,
    output logic [3:0]       cnt5,
    output logic [3:0]       cnt2,
    output logic [3:0]       cnt1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    // Gap counter only needs to hold COIN_GAP; keep at least one bit so the
    // declaration stays legal when the gap is disabled.
    localparam int GAP_W = (COIN_GAP > 1) ? $clog2(COIN_GAP + 1) : 1;

    localparam logic [AMT_W-1:0] V10 = AMT_W'(10);
    localparam logic [AMT_W-1:0] V5  = AMT_W'(5);
    localparam logic [AMT_W-1:0] V2  = AMT_W'(2);
    localparam logic [AMT_W-1:0] V1  = AMT_W'(1);

    state_t           state_q,  state_d;
    logic [GAP_W-1:0] gap_q,    gap_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [3:0]       coin_q,   coin_d;
    logic [AMT_W-1:0] rem_q,    rem_d;
    logic [3:0]       cnt10_q,  cnt10_d;
    logic [3:0]       cnt5_q,   cnt5_d;
    logic [3:0]       cnt2_q,   cnt2_d;
    logic [3:0]       cnt1_q,   cnt1_d;

    // Tallies stop at 15 rather than wrapping back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case statement can leave one unassigned and
        // infer a latch.
        state_d = state_q;
        gap_d   = gap_q;
        coin_d  = 4'b0000;
        rem_d   = rem_q;
        cnt10_d = cnt10_q;
        cnt5_d  = cnt5_q;
        cnt2_d  = cnt2_q;
        cnt1_d  = cnt1_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = amount;
                    cnt10_d = 4'd0;
                    cnt5_d  = 4'd0;
                    cnt2_d  = 4'd0;
                    cnt1_d  = 4'd0;
                    state_d = S_PICK;
                end
            end

            S_PICK: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_PULSE;
                    // Greedy choice; the selected coin never exceeds rem_q,
                    // so the subtraction cannot underflow.
                    if (rem_q >= V10) begin
                        coin_d  = 4'b1000;
                        rem_d   = rem_q - V10;
                        cnt10_d = sat_inc(cnt10_q);
                    end else if (rem_q >= V5) begin
                        coin_d  = 4'b0100;
                        rem_d   = rem_q - V5;
                        cnt5_d  = sat_inc(cnt5_q);
                    end else if (rem_q >= V2) begin
                        coin_d  = 4'b0010;
                        rem_d   = rem_q - V2;
                        cnt2_d  = sat_inc(cnt2_q);
                    end else begin
                        coin_d  = 4'b0001;
                        rem_d   = rem_q - V1;
                        cnt1_d  = sat_inc(cnt1_q);
                    end
                end
            end

            S_PULSE: begin
                if (COIN_GAP == 0) begin
                    state_d = S_PICK;
                end else begin
                    gap_d   = GAP_W'(COIN_GAP);
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                // Counter was loaded with COIN_GAP on entry; leaving when it
                // reads 1 gives exactly COIN_GAP cycles spent here.
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_PICK;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of where the FSM is heading,
        // so they line up with the state they describe.
        busy_d = (state_d == S_PICK) || (state_d == S_PULSE) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values computed before this edge, independent of order.
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            coin_q  <= 4'b0000;
            rem_q   <= '0;
            cnt10_q <= 4'd0;
            cnt5_q  <= 4'd0;
            cnt2_q  <= 4'd0;
            cnt1_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            coin_q  <= coin_d;
            rem_q   <= rem_d;
            cnt10_q <= cnt10_d;
            cnt5_q  <= cnt5_d;
            cnt2_q  <= cnt2_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign coin_out  = coin_q;
    assign remaining = rem_q;
    assign cnt10     = cnt10_q;
    assign cnt5      = cnt5_q;
    assign cnt2      = cnt2_q;
    assign cnt1      = cnt1_q;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Returns change to the customer after a purchase: it takes a change amount and emits one coin-eject pulse per coin.
- Coins are chosen greedily, largest denomination first, from 10/5/2/1.
- It sits downstream of the payment logic, which supplies the owed change, and drives the coin-hopper ejector outputs and the change display tallies.
- Denominations match the coin-input buttons (1/2/5/10).

Parameters:
- AMT_W, 5: width of the change amount; maximum amount is 2^AMT_W-1.
- COIN_GAP, 4: idle cycles inserted after each coin pulse to give the hopper settle time. 0 is legal.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to dispense `amount`; sampled only in IDLE.
- amount  in  AMT_W  change to return; latched on an accepted start.
- busy  out  1  high in PICK, PULSE and GAP.
- done  out  1  one-cycle pulse when dispensing is complete.
- coin_out  out  4  one-hot eject pulse, {bit3=10, bit2=5, bit1=2, bit0=1}; high for exactly one cycle per coin.
- remaining  out  AMT_W  change still to be dispensed.
- cnt10, cnt5, cnt2, cnt1  out  4 each  coins of each value ejected in the current transaction.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE; busy, done, coin_out, remaining and all cnt outputs are 0; gap counter is 0.
- Reset mid-operation: at the next edge all registers return to reset values. No further coin pulse is issued, and the partial transaction is abandoned.
- States: IDLE, PICK, PULSE, GAP, DONE. Every output is registered.
- IDLE:
  - start=1 → remaining<=amount, all cnt<=0, state<=PICK.
  - start=0 → stay in IDLE; remaining and cnt hold their last values so the display persists.
- PICK:
  - remaining==0 → DONE.
  - Otherwise → PULSE. On that same edge, pick the coin c = 10 if remaining>=10, else 5 if >=5, else 2 if >=2, else 1.
  - On that edge also: coin_out<=onehot(c), remaining<=remaining-c, cnt_c<=cnt_c+1.
  - cnt_c saturates at 15; remaining never underflows.
- PULSE: coin_out<=0. If COIN_GAP==0 → PICK; otherwise load the gap counter with COIN_GAP and go to GAP.
- GAP: decrement the gap counter each cycle; after COIN_GAP cycles in GAP → PICK.
- DONE: done=1 for this single cycle, busy=0 → IDLE.
- Timing:
  - Coin pulses are spaced COIN_GAP+2 cycles apart.
  - If start is accepted at edge E0, the first coin_out is visible after edge E0+1.
  - For n coins, done is visible after edge E0 + n·(COIN_GAP+2) + 1.
- start while busy or in DONE is ignored; no queuing.
- start held high continuously re-triggers only from IDLE. It is the upstream's job to pulse start.
- amount=0 → PICK → DONE: no coins are ejected, done pulses after edge E0+1, and all cnt outputs are 0.
- amount is only sampled on the accepting edge; later changes have no effect on the transaction.
- At most one bit of coin_out is ever high, and never in two consecutive cycles.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 → all outputs 0, state IDLE, no coin_out.
- amount=18, COIN_GAP=4:
  - coin_out sequence is 1000, 0100, 0010, 0001, each pulse 6 cycles apart.
  - Final cnt10=1, cnt5=1, cnt2=1, cnt1=1, remaining=0.
  - done pulses 25 cycles after the start edge.
- amount=31 → three 1000 pulses then one 0001; cnt10=3, cnt1=1. Then amount=7 → 0100, 0010; counts clear on start, giving cnt5=1, cnt2=1.
- amount=0 → done 1 cycle after acceptance, busy high for exactly 1 cycle, coin_out never asserted.
- start with amount=9 pulsed again mid-transaction of amount=12 → second start ignored; coins 10 then 2 only; done pulses once.
- rst asserted in GAP after the first coin of amount=18 → outputs 0 next edge, no further coin_out. A subsequent start with amount=3 yields 0010 then 0001.
- COIN_GAP=0, amount=4 → two 0010 pulses exactly 2 cycles apart.
